// File: rtl/ultrasonic_scheduler.sv
// Periodic / one-shot measurement scheduler for an ultrasonic ranging block.
// Define US_AVG_EN to publish a 4-capture running mean instead of raw distances.
module ultrasonic_scheduler #(
  parameter int TICK_DIV   = 100,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 40000,
  parameter int NEAR_CM    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       single,
  input  logic       us_done,
  input  logic [8:0] us_distance,
  output logic       us_start,
  output logic [8:0] dist_out,
  output logic       dist_valid,
  output logic       near,
  output logic       timeout_err,
  output logic       busy,
  output logic [1:0] o_state
);

  localparam int DW = $clog2(TICK_DIV) + 1;
  localparam int PW = $clog2(PERIOD_US) + 1;
  localparam int TW = $clog2(TIMEOUT_US) + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PER_TERM = PW'(PERIOD_US);
  localparam logic [TW-1:0] TMO_TERM = TW'(TIMEOUT_US);
  localparam logic [8:0]    OOR      = 9'd511;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    HOLDOFF   = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] timeout_cnt;
  logic          done_prev;
  logic          tick;
  logic          done_rise;
  logic          capture;
  logic [8:0]    cap_dist;

  function automatic logic [PW-1:0] sat_inc_p(input logic [PW-1:0] v);
    return (v == PER_TERM) ? v : v + PW'(1);
  endfunction

  function automatic logic [TW-1:0] sat_inc_t(input logic [TW-1:0] v);
    return (v == TMO_TERM) ? v : v + TW'(1);
  endfunction

  function automatic logic is_near(input logic [8:0] d);
    return (int'(d) < NEAR_CM) && (d != OOR);
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign done_rise = us_done & ~done_prev;
  assign capture   = (state == WAIT_DONE) && done_rise;
  assign o_state   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

`ifdef US_AVG_EN
  // Three most recent in-range captures; the incoming sample is the fourth.
  logic [8:0] win0, win1, win2;
  logic       win_valid;

  function automatic logic [8:0] avg4(input logic [8:0] a, input logic [8:0] b,
                                      input logic [8:0] c, input logic [8:0] d);
    logic [10:0] s;
    s = 11'(a) + 11'(b) + 11'(c) + 11'(d);
    return 9'(s >> 2);
  endfunction

  always_comb begin
    cap_dist = us_distance;
    if (us_distance != OOR && win_valid)
      cap_dist = avg4(win0, win1, win2, us_distance);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win0      <= '0;
      win1      <= '0;
      win2      <= '0;
      win_valid <= 1'b0;
    end else if (capture) begin
      if (us_distance == OOR) begin
        win_valid <= 1'b0;
      end else if (!win_valid) begin
        win0      <= us_distance;
        win1      <= us_distance;
        win2      <= us_distance;
        win_valid <= 1'b1;
      end else begin
        win2 <= win1;
        win1 <= win0;
        win0 <= us_distance;
      end
    end
  end
`else
  always_comb cap_dist = us_distance;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      us_start    <= 1'b0;
      dist_out    <= '0;
      dist_valid  <= 1'b0;
      near        <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      period_cnt  <= '0;
      timeout_cnt <= '0;
      done_prev   <= 1'b0;
    end else begin
      done_prev  <= us_done;
      us_start   <= 1'b0;
      dist_valid <= 1'b0;
      if (tick) begin
        period_cnt  <= sat_inc_p(period_cnt);
        timeout_cnt <= sat_inc_t(timeout_cnt);
      end
      case (state)
        IDLE: begin
          if (enable || single) begin
            state    <= START;
            us_start <= 1'b1;
            busy     <= 1'b1;
          end
        end
        START: begin
          period_cnt  <= '0;
          timeout_cnt <= '0;
          state       <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done edge on the timeout cycle still counts as a good capture.
          if (done_rise) begin
            dist_out    <= cap_dist;
            dist_valid  <= 1'b1;
            near        <= is_near(cap_dist);
            timeout_err <= 1'b0;
            state       <= HOLDOFF;
          end else if (timeout_cnt == TMO_TERM) begin
            timeout_err <= 1'b1;
            state       <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (period_cnt == PER_TERM) begin
            if (enable) begin
              state    <= START;
              us_start <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ultrasonic_scheduler.md
ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

Interface
REQ-001 Parameter TICK_DIV, 100, clk cycles per 1 us tick.
REQ-002 Parameter PERIOD_US, 60000, minimum us between successive us_start pulses.
REQ-003 Parameter TIMEOUT_US, 40000, max us from us_start to us_done before timeout.
REQ-004 Parameter NEAR_CM, 10, proximity threshold in cm.
REQ-005 clk  input  1  clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  level; continuous periodic ranging while high.
REQ-008 single  input  1  one-cycle pulse; request one measurement when idle.
REQ-009 us_done  input  1  done level from ranging block.
REQ-010 us_distance  input  9  cm from ranging block; 511 = out of range.
REQ-011 us_start  output  1  one-cycle start pulse to ranging block.
REQ-012 dist_out  output  9  latest published distance, cm.
REQ-013 dist_valid  output  1  one-cycle pulse when dist_out updates.
REQ-014 near  output  1  high while dist_out < NEAR_CM and dist_out != 511.
REQ-015 timeout_err  output  1  set on timeout, cleared by next capture.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 o_state  output  2  state code: IDLE=0, START=1, WAIT_DONE=2, HOLDOFF=3.

Function
REQ-018 Internal divider SHALL emit a 1-cycle us tick every TICK_DIV clks, free-running from reset.
REQ-019 IDLE: enable=1 or single=1 SHALL go to START next cycle; both together count as one request.
REQ-020 START: us_start=1 for exactly this cycle; period and timeout counters cleared; next state WAIT_DONE.
REQ-021 WAIT_DONE: rising edge of us_done (registered previous-level compare) SHALL capture us_distance and go to HOLDOFF.
REQ-022 Capture SHALL update dist_out and pulse dist_valid one cycle after the edge cycle; timeout_err cleared same cycle.
REQ-023 WAIT_DONE: timeout counter reaching TIMEOUT_US ticks SHALL set timeout_err, leave dist_out unchanged, no dist_valid, go to HOLDOFF.
REQ-024 us_done edge and timeout in same cycle: capture SHALL win; timeout_err not set.
REQ-025 Period counter SHALL count ticks from START; HOLDOFF exits when it reaches PERIOD_US: to START if enable=1, else IDLE.
REQ-026 enable falling mid-measurement SHALL not abort; current measurement and holdoff complete, then IDLE.
REQ-027 single while busy SHALL be ignored (not queued).
REQ-028 Counters SHALL saturate at their terminal value, never wrap; widths = clog2 of parameter +1.
REQ-029 near SHALL be registered, updated only when dist_out updates.

Reset
REQ-030 reset SHALL force IDLE, us_start=0, dist_out=0, dist_valid=0, near=0, timeout_err=0, busy=0, o_state=0, all counters and averaging window cleared, immediately and asynchronously.
REQ-031 reset mid-WAIT_DONE SHALL discard the pending measurement; no dist_valid after release until a new capture.

Configuration
REQ-032 Macro US_AVG_EN defined: dist_out SHALL be mean of last 4 in-range captures (11-bit sum, >>2, truncated); first in-range capture after reset or out-of-range preloads all 4 slots.
REQ-033 With US_AVG_EN: capture of 511 SHALL set dist_out=511 and invalidate the window; dist_valid still pulses.
REQ-034 US_AVG_EN undefined: dist_out SHALL be the raw captured us_distance; no window storage.

Verification (bench: TICK_DIV=4, PERIOD_US=100, TIMEOUT_US=50, NEAR_CM=10)
REQ-035 single pulse, model returns us_done rise with 123 after 30 us -> one us_start, dist_out=123, one dist_valid, near=0, IDLE after 100 us from start.
REQ-036 enable held, model returns 5 -> us_start every 400 clks, near=1 after first capture.
REQ-037 model never asserts us_done -> timeout_err=1 at 50 us, dist_out unchanged, no dist_valid; next good capture clears timeout_err.
REQ-038 us_done edge on exact timeout cycle -> capture taken, timeout_err=0.
REQ-039 reset asserted in WAIT_DONE then released, done edge arrives later -> no dist_valid, state IDLE, dist_out=0.
REQ-040 US_AVG_EN, captures 100,100,100,200 -> dist_out 100,100,100,125; then 511 -> 511; then 40 -> 40.
